alu_writeback: RTL and testbench

Result/writeback stage directly downstream of the ALU in the multi-cycle datapath. It captures the ALU's low result, high result and NZCV flags on a capture strobe, and holds the low word as the architectural ALUOut. It updates the NZCV flag register under FlagW control, then sequences one or two register-file write beats over a valid/ready handshake: one beat normally, two for UMULL/SMULL (RdLo, then RdHi).

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_writeback.sv | 151 +++++++++++++++
 tb/tb_alu_writeback.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, NZCV bit positions
// and the writeback sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_UMUL = 3'b101;
  localparam logic [2:0] ALU_SMUL = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    WB_LO,
    WB_HI
  } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// ALU result latch, NZCV flag register and one/two-beat
// register-file writeback sequencer.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_valid,
  output logic             cap_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_result_hi,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_write,
  input  logic             reg_write,
  input  logic [RADDR-1:0] rd_lo,
  input  logic [RADDR-1:0] rd_hi,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RADDR-1:0] wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy
);

  wb_state_e        state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [RADDR-1:0] rd_lo_q, rd_lo_d;
  logic [RADDR-1:0] rd_hi_q, rd_hi_d;
  logic             is_long_q, is_long_d;
  logic [3:0]       flags_q, flags_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RADDR-1:0] wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic final_beat;
  logic cap;
  logic cap_long;

  assign final_beat = (state_q == WB_HI) ||
                      (state_q == WB_LO && !is_long_q);
  assign cap_ready  = (state_q == IDLE) ||
                      (final_beat && wb_ready);
  assign cap        = cap_valid && cap_ready;
  assign cap_long   = (alu_control == ALU_UMUL) ||
                      (alu_control == ALU_SMUL);

  // Long multiplies derive N,Z from the full 2*WIDTH product
  always_comb begin
    flags_d = flags_q;
    if (cap) begin
      if (cap_long) begin
        if (flag_write[1]) begin
          flags_d[FLAG_N] = alu_result_hi[WIDTH-1];
          flags_d[FLAG_Z] = (alu_result_hi == '0) &&
                            (alu_result == '0);
        end
      end else begin
        if (flag_write[1]) begin
          flags_d[FLAG_N] = alu_flags[FLAG_N];
          flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_write[0]) begin
          flags_d[FLAG_C] = alu_flags[FLAG_C];
          flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    hi_d      = hi_q;
    rd_lo_d   = rd_lo_q;
    rd_hi_d   = rd_hi_q;
    is_long_d = is_long_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    unique case (state_q)
      IDLE:    state_d = IDLE;
      WB_LO:   if (wb_ready) state_d = is_long_q ? WB_HI : IDLE;
      WB_HI:   if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cap) begin
      alu_out_d = alu_result;
      hi_d      = alu_result_hi;
      rd_lo_d   = rd_lo;
      rd_hi_d   = rd_hi;
      is_long_d = cap_long;
      state_d   = reg_write ? WB_LO : IDLE;
    end

    // Beat outputs follow the next state so they are registered
    unique case (state_d)
      WB_LO: begin
        wb_addr_d = rd_lo_d;
        wb_data_d = alu_out_d;
      end
      WB_HI: begin
        wb_addr_d = rd_hi_d;
        wb_data_d = hi_d;
      end
      default: ;
    endcase

    wb_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      alu_out_q  <= '0;
      hi_q       <= '0;
      rd_lo_q    <= '0;
      rd_hi_q    <= '0;
      is_long_q  <= 1'b0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_out_q  <= alu_out_d;
      hi_q       <= hi_d;
      rd_lo_q    <= rd_lo_d;
      rd_hi_q    <= rd_hi_d;
      is_long_q  <= is_long_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign flags    = flags_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Randomised and directed checks of alu_writeback against a
// queue-of-beats reference model.
module tb_alu_writeback;

  logic        clk = 0;
  logic        reset = 0;
  logic        cap_valid = 0;
  logic        cap_ready;
  logic [2:0]  alu_control = 0;
  logic [31:0] alu_result = 0;
  logic [31:0] alu_result_hi = 0;
  logic [3:0]  alu_flags = 0;
  logic [1:0]  flag_write = 0;
  logic        reg_write = 0;
  logic [3:0]  rd_lo = 0;
  logic [3:0]  rd_hi = 0;
  logic [31:0] alu_out;
  logic [3:0]  flags;
  logic        wb_valid;
  logic        wb_ready = 0;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_writeback #(.WIDTH(32), .RADDR(4)) dut (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .alu_control(alu_control), .alu_result(alu_result),
    .alu_result_hi(alu_result_hi), .alu_flags(alu_flags),
    .flag_write(flag_write), .reg_write(reg_write),
    .rd_lo(rd_lo), .rd_hi(rd_hi),
    .alu_out(alu_out), .flags(flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending register-file writes as a queue
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t       beats[$];
  logic [3:0]  m_flags;
  logic [31:0] m_alu_out;
  bit          m_rdy;
  bit          m_long;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      beats.delete();
      m_flags = 0;
      m_alu_out = 0;
    end else begin
      m_rdy = beats.size() == 0 ||
              (beats.size() == 1 && wb_ready);
      if (beats.size() > 0 && wb_ready) void'(beats.pop_front());
      if (cap_valid && m_rdy) begin
        m_long = alu_control == 3'd5 || alu_control == 3'd6;
        m_alu_out = alu_result;
        if (m_long) begin
          if (flag_write[1]) begin
            m_flags[3] = alu_result_hi >= 32'h8000_0000;
            m_flags[2] = alu_result_hi == 0 && alu_result == 0;
          end
        end else begin
          if (flag_write[1]) m_flags[3:2] = alu_flags[3:2];
          if (flag_write[0]) m_flags[1:0] = alu_flags[1:0];
        end
        if (reg_write) begin
          beats.push_back('{rd_lo, alu_result});
          if (m_long) beats.push_back('{rd_hi, alu_result_hi});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] lo,
                       input logic [31:0] hi, input logic [3:0] fl,
                       input logic [1:0] fw, input logic rw,
                       input logic [3:0] rl, input logic [3:0] rh);
    cap_valid = 1;
    alu_control = op;
    alu_result = lo;
    alu_result_hi = hi;
    alu_flags = fl;
    flag_write = fw;
    reg_write = rw;
    rd_lo = rl;
    rd_hi = rh;
  endtask

  task automatic test_reset();
    reset = 0;
    #12;
    tests++;
    if ({wb_valid, busy, cap_ready} !== 3'b001 ||
        alu_out !== 0 || flags !== 0 ||
        wb_addr !== 0 || wb_data !== 0) begin
      fails++;
      $display("FAIL reset: valid=%b busy=%b rdy=%b out=%h fl=%h a=%h d=%h want 0,0,1,0,0,0,0",
               wb_valid, busy, cap_ready, alu_out, flags, wb_addr, wb_data);
    end
    @(negedge clk);
    reset = 1;
    cyc();
  endtask

  task automatic test_add();
    wb_ready = 1;
    drive(3'b000, 32'h5, 0, 4'b0000, 2'b11, 1, 4'd3, 4'd0);
    cyc();
    cap_valid = 0;
    tests++;
    if (wb_valid !== 1 || wb_addr !== 3 || wb_data !== 5 ||
        flags !== 0 || alu_out !== 5) begin
      fails++;
      $display("FAIL add_beat: v=%b a=%0d d=%h fl=%b out=%h want 1,3,5,0000,5",
               wb_valid, wb_addr, wb_data, flags, alu_out);
    end
    cyc();
    tests++;
    if (busy !== 0 || wb_valid !== 0) begin
      fails++;
      $display("FAIL add_done: busy=%b v=%b want 0,0", busy, wb_valid);
    end
  endtask

  task automatic test_umul();
    wb_ready = 1;
    drive(3'b000, 32'h7, 0, 4'b0011, 2'b01, 0, 4'd0, 4'd0);
    cyc();
    drive(3'b101, 32'h0, 32'h8000_0000, 4'b0100, 2'b11, 1, 4'd1, 4'd2);
    cyc();
    cap_valid = 0;
    tests++;
    if (wb_valid !== 1 || wb_addr !== 1 || wb_data !== 0 ||
        flags !== 4'b1011) begin
      fails++;
      $display("FAIL umul_lo: v=%b a=%0d d=%h fl=%b want 1,1,0,1011",
               wb_valid, wb_addr, wb_data, flags);
    end
    cyc();
    tests++;
    if (wb_valid !== 1 || wb_addr !== 2 || wb_data !== 32'h8000_0000) begin
      fails++;
      $display("FAIL umul_hi: v=%b a=%0d d=%h want 1,2,80000000",
               wb_valid, wb_addr, wb_data);
    end
    cyc();
    tests++;
    if (busy !== 0 || wb_valid !== 0) begin
      fails++;
      $display("FAIL umul_done: busy=%b v=%b want 0,0", busy, wb_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] fl0;
    wb_ready = 0;
    drive(3'b000, 32'h1234, 0, 4'b0000, 2'b00, 1, 4'd7, 4'd0);
    cyc();
    fl0 = flags;
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 32'hDEAD, 0, 4'b1111, 2'b11, 1, 4'd9, 4'd0);
      #1;
      tests++;
      if (wb_valid !== 1 || wb_addr !== 7 || wb_data !== 32'h1234 ||
          cap_ready !== 0 || alu_out !== 32'h1234 || flags !== fl0) begin
        fails++;
        $display("FAIL stall%0d: v=%b a=%0d d=%h rdy=%b out=%h fl=%b want 1,7,1234,0,1234,%b",
                 i, wb_valid, wb_addr, wb_data, cap_ready, alu_out, flags, fl0);
      end
      cyc();
    end
    cap_valid = 0;
    wb_ready = 1;
    cyc();
    tests++;
    if (wb_valid !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL stall_release: v=%b busy=%b want 0,0", wb_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1;
    drive(3'b010, 32'h11, 0, 4'b0000, 2'b00, 1, 4'd4, 4'd0);
    cyc();
    drive(3'b011, 32'h22, 0, 4'b0000, 2'b00, 1, 4'd5, 4'd0);
    #1;
    tests++;
    if (cap_ready !== 1 || wb_addr !== 4 || wb_data !== 32'h11) begin
      fails++;
      $display("FAIL b2b_first: rdy=%b a=%0d d=%h want 1,4,11",
               cap_ready, wb_addr, wb_data);
    end
    cyc();
    cap_valid = 0;
    tests++;
    if (wb_valid !== 1 || wb_addr !== 5 || wb_data !== 32'h22) begin
      fails++;
      $display("FAIL b2b_second: v=%b a=%0d d=%h want 1,5,22",
               wb_valid, wb_addr, wb_data);
    end
    cyc();
  endtask

  task automatic test_no_write();
    wb_ready = 1;
    drive(3'b000, 32'h0, 0, 4'b0000, 2'b11, 0, 4'd0, 4'd0);
    cyc();
    drive(3'b001, 32'h99, 0, 4'b0110, 2'b01, 0, 4'd6, 4'd0);
    cyc();
    cap_valid = 0;
    tests++;
    if (wb_valid !== 0 || flags !== 4'b0010 || alu_out !== 32'h99) begin
      fails++;
      $display("FAIL no_write: v=%b fl=%b out=%h want 0,0010,99",
               wb_valid, flags, alu_out);
    end
  endtask

  task automatic test_reset_mid();
    wb_ready = 1;
    drive(3'b110, 32'hAAAA, 32'h5555, 4'b0000, 2'b11, 1, 4'd8, 4'd9);
    cyc();
    cap_valid = 0;
    cyc();
    tests++;
    if (wb_valid !== 1 || wb_addr !== 9 || wb_data !== 32'h5555) begin
      fails++;
      $display("FAIL mid_hi: v=%b a=%0d d=%h want 1,9,5555",
               wb_valid, wb_addr, wb_data);
    end
    #1 reset = 0;
    #1;
    tests++;
    if (wb_valid !== 0 || busy !== 0 || cap_ready !== 1 ||
        wb_addr !== 0 || wb_data !== 0 || alu_out !== 0 || flags !== 0) begin
      fails++;
      $display("FAIL mid_reset: v=%b busy=%b rdy=%b a=%0d d=%h out=%h fl=%b want zeros, rdy=1",
               wb_valid, busy, cap_ready, wb_addr, wb_data, alu_out, flags);
    end
    cyc();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests++;
      if (wb_valid !== 0) begin
        fails++;
        $display("FAIL mid_after%0d: v=%b want 0", i, wb_valid);
      end
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      cap_valid = $urandom_range(0, 1);
      alu_control = 3'($urandom_range(0, 7));
      alu_result = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      alu_result_hi = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      alu_flags = 4'($urandom_range(0, 15));
      flag_write = 2'($urandom_range(0, 3));
      reg_write = ($urandom_range(0, 3) != 0);
      rd_lo = 4'($urandom_range(0, 15));
      rd_hi = ($urandom_range(0, 3) == 0) ? rd_lo : 4'($urandom_range(0, 15));
      wb_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = beats.size() == 0 || (beats.size() == 1 && wb_ready);
      tests++;
      if (cap_ready !== exp_rdy || wb_valid !== (beats.size() != 0) ||
          busy !== (beats.size() != 0) ||
          alu_out !== m_alu_out || flags !== m_flags) begin
        fails++;
        $display("FAIL rand%0d: rdy=%b v=%b busy=%b out=%h fl=%b want %b,%b,%b,%h,%b",
                 i, cap_ready, wb_valid, busy, alu_out, flags, exp_rdy,
                 beats.size() != 0, beats.size() != 0, m_alu_out, m_flags);
      end else if (beats.size() != 0 &&
                   (wb_addr !== beats[0].addr || wb_data !== beats[0].data)) begin
        fails++;
        $display("FAIL rand_beat%0d: a=%0d d=%h want %0d,%h",
                 i, wb_addr, wb_data, beats[0].addr, beats[0].data);
      end
      cyc();
    end
    cap_valid = 0;
    wb_ready = 1;
    for (int i = 0; i < 4; i++) cyc();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_umul();
    test_backpressure();
    test_back_to_back();
    test_no_write();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
